// File: rtl/jtag_dma_engine.sv
// Bus-side DMA master for the JTAG ping-pong buffer: moves one buffer half to or from the
// system bus in bursts of up to MAX_BURST words and reports when the halves may be swapped.
module jtag_dma_engine #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        launch_write,
  input  logic        launch_read,
  input  logic [31:0] start_address,
  input  logic [3:0]  byte_enables,
  input  logic [7:0]  block_size,
  output logic        switch_ready,
  output logic        done,
  output logic        error,
  output logic [8:0]  pp_address,
  output logic        pp_writeEnable,
  output logic [31:0] pp_dataIn,
  input  logic [31:0] pp_dataOut,
  output logic        request,
  input  logic        granted,
  output logic        begin_transaction_out,
  output logic [31:0] address_data_out,
  output logic [3:0]  byte_enables_out,
  output logic [7:0]  burst_size_out,
  output logic        read_n_write_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  input  logic        busy_in,
  input  logic        data_valid_in,
  input  logic [31:0] address_data_in,
  input  logic        end_transaction_in,
  input  logic        error_in
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StRequest  = 4'd1;
  localparam logic [3:0] StBegin    = 4'd2;
  localparam logic [3:0] StWFetch   = 4'd3;
  localparam logic [3:0] StWData    = 4'd4;
  localparam logic [3:0] StWEnd     = 4'd5;
  localparam logic [3:0] StRData    = 4'd6;
  localparam logic [3:0] StRWaitEnd = 4'd7;
  localparam logic [3:0] StDone     = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic [8:0]  remaining_q, remaining_d;
  logic [7:0]  index_q, index_d;
  logic [4:0]  blen_q, blen_d;
  logic [4:0]  bleft_q, bleft_d;
  logic        error_q, error_d;
  logic        abort_q, abort_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wvld_q, wvld_d;

  logic [4:0]  burst_words;
  logic [4:0]  blen_m1;
  logic [31:0] addr_next;
  logic [31:0] wdata;
  logic        bus_window;

  assign burst_words = (remaining_q > 9'(MAX_BURST)) ? 5'(MAX_BURST) : remaining_q[4:0];
  assign blen_m1     = blen_q - 5'd1;
  assign addr_next   = addr_q + {25'd0, blen_q, 2'b00};
  // Buffer read data is only valid in the first data cycle; later stall cycles replay the copy.
  assign wdata       = wvld_q ? wdata_q : pp_dataOut;
  assign bus_window  = (state_q == StBegin) || (state_q == StWFetch) || (state_q == StWData) ||
                       (state_q == StWEnd) || (state_q == StRData) || (state_q == StRWaitEnd);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    rd_d        = rd_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    blen_d      = blen_q;
    bleft_d     = bleft_q;
    error_d     = error_q;
    abort_d     = abort_q;
    wdata_d     = wdata_q;
    wvld_d      = wvld_q;

    case (state_q)
      StIdle: begin
        if (launch_write || launch_read) begin
          addr_d      = start_address & 32'hFFFF_FFFC;
          be_d        = byte_enables;
          rd_d        = ~launch_write;
          remaining_d = {1'b0, block_size} + 9'd1;
          index_d     = '0;
          error_d     = 1'b0;
          abort_d     = 1'b0;
          state_d     = StRequest;
        end
      end
      StRequest: begin
        if (granted) begin
          blen_d  = burst_words;
          bleft_d = burst_words;
          state_d = StBegin;
        end
      end
      StBegin: begin
        state_d = rd_q ? StRData : StWFetch;
      end
      StWFetch: begin
        wvld_d  = 1'b0;
        state_d = StWData;
      end
      StWData: begin
        wdata_d = wdata;
        wvld_d  = 1'b1;
        if (!busy_in) begin
          index_d     = index_q + 8'd1;
          remaining_d = remaining_q - 9'd1;
          bleft_d     = bleft_q - 5'd1;
          state_d     = (bleft_q == 5'd1) ? StWEnd : StWFetch;
        end
      end
      StWEnd: begin
        addr_d  = addr_next;
        state_d = (abort_q || remaining_q == 9'd0) ? StDone : StRequest;
      end
      StRData: begin
        if (data_valid_in) begin
          index_d     = index_q + 8'd1;
          remaining_d = remaining_q - 9'd1;
          bleft_d     = bleft_q - 5'd1;
          if (bleft_q == 5'd1) begin
            if (end_transaction_in) begin
              addr_d  = addr_next;
              state_d = (remaining_q == 9'd1) ? StDone : StRequest;
            end else begin
              state_d = StRWaitEnd;
            end
          end
        end
      end
      StRWaitEnd: begin
        if (end_transaction_in) begin
          addr_d  = addr_next;
          state_d = (remaining_q == 9'd0) ? StDone : StRequest;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A bus error abandons the transfer; open write bursts still get their closing cycle.
    if (bus_window && error_in) begin
      error_d = 1'b1;
      if (!rd_q && state_q != StWEnd) begin
        abort_d = 1'b1;
        state_d = StWEnd;
      end else begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      be_q        <= '0;
      rd_q        <= 1'b0;
      remaining_q <= '0;
      index_q     <= '0;
      blen_q      <= '0;
      bleft_q     <= '0;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
      wdata_q     <= '0;
      wvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      blen_q      <= blen_d;
      bleft_q     <= bleft_d;
      error_q     <= error_d;
      abort_q     <= abort_d;
      wdata_q     <= wdata_d;
      wvld_q      <= wvld_d;
    end
  end

  always_comb begin
    switch_ready          = (state_q == StIdle);
    done                  = (state_q == StDone);
    error                 = error_q;
    request               = (state_q == StRequest) || (state_q == StBegin) ||
                            (state_q == StWFetch) || (state_q == StWData) ||
                            (state_q == StRData) || (state_q == StRWaitEnd);
    begin_transaction_out = 1'b0;
    address_data_out      = '0;
    byte_enables_out      = '0;
    burst_size_out        = '0;
    read_n_write_out      = 1'b0;
    data_valid_out        = 1'b0;
    end_transaction_out   = (state_q == StWEnd);
    pp_address            = '0;
    pp_writeEnable        = 1'b0;
    pp_dataIn             = '0;

    case (state_q)
      StBegin: begin
        begin_transaction_out = 1'b1;
        address_data_out      = addr_q;
        byte_enables_out      = rd_q ? 4'hF : be_q;
        burst_size_out        = {3'b000, blen_m1};
        read_n_write_out      = rd_q;
      end
      StWFetch: begin
        pp_address = {1'b0, index_q};
      end
      StWData: begin
        pp_address       = {1'b0, index_q};
        data_valid_out   = 1'b1;
        address_data_out = wdata;
        byte_enables_out = be_q;
      end
      StRData: begin
        if (data_valid_in) begin
          pp_address     = {1'b0, index_q};
          pp_writeEnable = 1'b1;
          pp_dataIn      = address_data_in;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/jtag_dma_engine.md
# jtag_dma_engine

System-clock DMA master that serves the bus side of the JTAG ping-pong buffer. On a write launch it reads the filled buffer half and issues bus write bursts. On a read launch it issues bus read bursts and fills the buffer half for the JTAG chain to shift out. It reports `switch_ready` so the JTAG chain knows when the buffer may be swapped.

## Interface
- `MAX_BURST`, 16: maximum words per bus burst; power of two, range 1..16.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `launch_write` in 1: one-cycle pulse; start buffer-to-bus transfer. Synchronized upstream.
- `launch_read` in 1: one-cycle pulse; start bus-to-buffer transfer. Synchronized upstream.
- `start_address` in 32: byte address; bits [1:0] ignored. Sampled at launch.
- `byte_enables` in 4: byte enables for all write beats. Sampled at launch.
- `block_size` in 8: transfer length = block_size+1 words (1..256). Sampled at launch.
- `switch_ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse when a transfer ends, normally or by error.
- `error` out 1: sticky error flag; cleared by the next launch.
- `pp_address` out 9: buffer word address, {1'b0, word index}.
- `pp_writeEnable` out 1: buffer write strobe.
- `pp_dataIn` out 32: buffer write data.
- `pp_dataOut` in 32: buffer read data; valid one cycle after `pp_address`.
- `request` out 1: bus request.
- `granted` in 1: bus grant.
- `begin_transaction_out` out 1: bus transaction start.
- `address_data_out` out 32: address in the begin cycle, write data in data beats.
- `byte_enables_out` out 4: bus byte enables.
- `burst_size_out` out 8: words in this burst minus one.
- `read_n_write_out` out 1: 1 = read.
- `data_valid_out` out 1: write beat valid.
- `end_transaction_out` out 1: ends a write transaction.
- `busy_in` in 1: slave stall.
- `data_valid_in` in 1: read beat valid.
- `address_data_in` in 32: read data.
- `end_transaction_in` in 1: slave ends a read transaction.
- `error_in` in 1: bus error.

## Operation
- States: IDLE, REQUEST, BEGIN, W_FETCH, W_DATA, W_END, R_DATA, R_WAIT_END, DONE.
- IDLE
  - `launch_write`: latch address, enables and size; index=0; clear `error`; go to REQUEST.
  - `launch_read`: same latching, then REQUEST.
  - Both pulses in the same cycle: write wins; the read is dropped.
  - Launches outside IDLE are ignored.
- REQUEST: `request`=1 and held until the burst ends. `granted` → BEGIN.
- BEGIN (one cycle)
  - `begin_transaction_out`=1, `address_data_out`=current address.
  - `burst_size_out` = min(remaining, MAX_BURST) − 1.
  - `read_n_write_out`, `byte_enables_out` driven (byte enables forced to 4'hF on reads).
  - Next state: write → W_FETCH; read → R_DATA.
- W_FETCH (one cycle): `pp_address`={0,index}. Next → W_DATA.
- W_DATA
  - `data_valid_out`=1, `address_data_out`=captured `pp_dataOut`.
  - Hold all outputs stable while `busy_in`=1.
  - Beat accepted when `busy_in`=0: index++, remaining−−.
  - More beats in this burst → W_FETCH; otherwise → W_END.
- W_END (one cycle)
  - `end_transaction_out`=1; drop `request`; address += 4·burst words.
  - remaining>0 → REQUEST; else → DONE.
- R_DATA
  - Each `data_valid_in`: `pp_writeEnable`=1, `pp_dataIn`=`address_data_in`, `pp_address`={0,index}; index++, remaining−−.
  - Last beat of the burst → R_WAIT_END. If `end_transaction_in` arrives in the same cycle, skip R_WAIT_END.
- R_WAIT_END: on `end_transaction_in`, advance address; remaining>0 → REQUEST, else → DONE.
- DONE (one cycle): `done`=1, then IDLE.
- `error_in` in BEGIN..R_WAIT_END
  - Set `error`.
  - Write burst: assert `end_transaction_out` for one cycle.
  - Go to DONE; remaining words are abandoned.
- Arithmetic
  - Index is 8-bit and never wraps within a transfer (≤256 words).
  - Address wraps modulo 2^32.
  - Remaining count is 9-bit.

## Timing
- Reset: state=IDLE; all registered outputs 0; `switch_ready`=1 (decoded from IDLE) in the first cycle after reset.
- Reset mid-transfer: next cycle is IDLE, `request` and all strobes are 0, no `end_transaction_out` is issued, and `done` does not pulse.
- Launch → `request`: 1 cycle. `granted` → `begin_transaction_out`: 1 cycle.
- Write throughput: one beat per 2 cycles with no stalls (fetch + data).
- Read: buffer write occurs in the same cycle as `data_valid_in`; no added latency.
- `switch_ready` falls the cycle after launch and rises the cycle after DONE.

## Test plan
- Write, block_size=0, addr 0x1000, be=4'b0011, buffer[0]=0xDEADBEEF.
  - Response: one burst with burst_size_out=0 and beat 0xDEADBEEF; `end_transaction_out`; `done`, no `error`.
- Write, block_size=19, addr 0x2000.
  - Response: burst of 16 words at 0x2000, then 4 words at 0x2040.
  - With `busy_in` held 3 cycles on beat 5, data is held stable and no beat is duplicated or lost.
- Read, block_size=2, slave returns 0xA, 0xB, 0xC.
  - Response: `pp_writeEnable` at addresses 0, 1, 2 with those values; `done` after `end_transaction_in`.
- `error_in` on beat 3 of a 16-word write.
  - Response: `end_transaction_out` pulse, `error`=1, `done`; the next launch clears `error`.
- `launch_write` and `launch_read` in the same cycle.
  - Response: write executes; a launch during the transfer is ignored.
- `reset` during W_DATA.
  - Response: next cycle IDLE, `request`=0, `switch_ready`=1, no `done`.
